// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types (word, ALU opcode, ALU arbiter state)
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA} aluop_t;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arbstate_t;
endpackage

// File: rtl/alu_arb_if.sv
// alu_arb_if: requester-side bundle of alu_arbiter (req valid/ready/aluop/A/B, rsp valid/ready/result/flags, busy)
interface alu_arb_if #(parameter int NREQ = 2);
  import cpu_types_pkg::*;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  aluop_t [NREQ-1:0] req_aluop;
  word_t [NREQ-1:0] req_portA;
  word_t [NREQ-1:0] req_portB;
  logic [NREQ-1:0] rsp_valid;
  logic [NREQ-1:0] rsp_ready;
  word_t rsp_portOut;
  logic rsp_negative;
  logic rsp_overflow;
  logic rsp_zero;
  logic busy;
  modport arb (
    input  req_valid, req_aluop, req_portA, req_portB, rsp_ready,
    output req_ready, rsp_valid, rsp_portOut, rsp_negative, rsp_overflow, rsp_zero, busy
  );
  modport tb (
    output req_valid, req_aluop, req_portA, req_portB, rsp_ready,
    input  req_ready, rsp_valid, rsp_portOut, rsp_negative, rsp_overflow, rsp_zero, busy
  );
endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick; valid/ptr in, one-hot grant and winner idx out (first valid from ptr upward, mod N)
module rr_picker #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  always_comb begin
    j = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr) + k) % N);
      idx = valid[j] ? j : idx;
    end
    grant = (|valid) ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU; CLK/RST, per-requester req/rsp valid-ready channels, registered result+flags, busy, alu_* to/from the ALU
module alu_arbiter import cpu_types_pkg::*; #(
  parameter int NREQ = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  aluop_t [NREQ-1:0] req_aluop,
  input  word_t [NREQ-1:0]  req_portA,
  input  word_t [NREQ-1:0]  req_portB,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output word_t             rsp_portOut,
  output logic              rsp_negative,
  output logic              rsp_overflow,
  output logic              rsp_zero,
  output logic              busy,
  output word_t             alu_portA,
  output word_t             alu_portB,
  output aluop_t            alu_aluop,
  input  word_t             alu_portOut,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  input  logic              alu_zero
);
  localparam int PTR_W = $clog2(NREQ);
  arbstate_t state, nxt;
  logic [PTR_W-1:0] rr_ptr, owner, win;
  logic [NREQ-1:0] grant;
  logic acc;
  word_t op_a, op_b;
  aluop_t op_op;
  rr_picker #(.N(NREQ), .W(PTR_W)) picker (
    .valid(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(win)
  );
  assign alu_portA = op_a;
  assign alu_portB = op_b;
  assign alu_aluop = op_op;
  always_comb begin
    acc = (state == IDLE) && (|req_valid);
    nxt = (state == IDLE) ? (acc ? EXEC : IDLE) : (state == EXEC) ? RESP : (rsp_ready[owner] ? IDLE : RESP);
    req_ready = ((state == IDLE) && !RST) ? grant : '0;
    rsp_valid = (state == RESP) ? (NREQ'(1) << owner) : '0;
    busy = state != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      op_a <= '0;
      op_b <= '0;
      op_op <= aluop_t'(0);
      rsp_portOut <= '0;
      rsp_negative <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero <= 1'b0;
    end else begin
      state <= nxt;
      if (acc) begin
        owner <= win;
        rr_ptr <= (win == PTR_W'(NREQ - 1)) ? '0 : win + PTR_W'(1);
        op_a <= req_portA[win];
        op_b <= req_portB[win];
        op_op <= req_aluop[win];
      end
      if (state == EXEC) begin
        rsp_portOut <= alu_portOut;
        rsp_negative <= alu_negative;
        rsp_overflow <= alu_overflow;
        rsp_zero <= alu_zero;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with NREQ=2 and NREQ=3 instances and a behavioural ALU
module tb_alu_arbiter;
  import cpu_types_pkg::*;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 CLK = ~CLK;
  alu_arb_if #(.NREQ(2)) a2 ();
  alu_arb_if #(.NREQ(3)) a3 ();
  word_t alu2_a, alu2_b, alu2_out, alu3_a, alu3_b, alu3_out;
  aluop_t alu2_op, alu3_op;
  logic alu2_n, alu2_v, alu2_z, alu3_n, alu3_v, alu3_z;
  function automatic logic [34:0] alu_f(aluop_t op, word_t a, word_t b);
    word_t r;
    logic v;
    v = 1'b0;
    case (op)
      ALU_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: r = a << b[4:0];
      ALU_SRL: r = a >> b[4:0];
      default: r = $signed(a) >>> b[4:0];
    endcase
    return {r, r[31], v, r == 32'd0};
  endfunction
  assign {alu2_out, alu2_n, alu2_v, alu2_z} = alu_f(alu2_op, alu2_a, alu2_b);
  assign {alu3_out, alu3_n, alu3_v, alu3_z} = alu_f(alu3_op, alu3_a, alu3_b);
  alu_arbiter #(.NREQ(2)) d2 (
    .CLK(CLK), .RST(RST),
    .req_valid(a2.req_valid), .req_ready(a2.req_ready), .req_aluop(a2.req_aluop),
    .req_portA(a2.req_portA), .req_portB(a2.req_portB),
    .rsp_valid(a2.rsp_valid), .rsp_ready(a2.rsp_ready), .rsp_portOut(a2.rsp_portOut),
    .rsp_negative(a2.rsp_negative), .rsp_overflow(a2.rsp_overflow), .rsp_zero(a2.rsp_zero),
    .busy(a2.busy),
    .alu_portA(alu2_a), .alu_portB(alu2_b), .alu_aluop(alu2_op), .alu_portOut(alu2_out),
    .alu_negative(alu2_n), .alu_overflow(alu2_v), .alu_zero(alu2_z)
  );
  alu_arbiter #(.NREQ(3)) d3 (
    .CLK(CLK), .RST(RST),
    .req_valid(a3.req_valid), .req_ready(a3.req_ready), .req_aluop(a3.req_aluop),
    .req_portA(a3.req_portA), .req_portB(a3.req_portB),
    .rsp_valid(a3.rsp_valid), .rsp_ready(a3.rsp_ready), .rsp_portOut(a3.rsp_portOut),
    .rsp_negative(a3.rsp_negative), .rsp_overflow(a3.rsp_overflow), .rsp_zero(a3.rsp_zero),
    .busy(a3.busy),
    .alu_portA(alu3_a), .alu_portB(alu3_b), .alu_aluop(alu3_op), .alu_portOut(alu3_out),
    .alu_negative(alu3_n), .alu_overflow(alu3_v), .alu_zero(alu3_z)
  );
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin a2.req_aluop[i] = ALU_ADD; a2.req_portA[i] = '0; a2.req_portB[i] = '0; end
    for (int i = 0; i < 3; i++) begin a3.req_aluop[i] = ALU_ADD; a3.req_portA[i] = '0; a3.req_portB[i] = '0; end
    a2.rsp_ready = '0;
    a3.rsp_ready = '0;
    a3.req_valid = '0;
    a2.req_valid = 2'b11;
    RST = 1'b1;
    tick();
    tick();
    #1;
    checks++; if (a2.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", a2.req_ready); end
    checks++; if (a2.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", a2.rsp_valid); end
    checks++; if (a2.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a2.busy); end
    checks++; if (d2.state !== IDLE) begin errors++; $display("FAIL reset_state: got %s want IDLE", d2.state.name()); end
    checks++; if (d2.rr_ptr !== 1'b0 || d3.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr: got %0d/%0d want 0/0", d2.rr_ptr, d3.rr_ptr); end
    checks++; if ({a2.rsp_portOut, a2.rsp_negative, a2.rsp_overflow, a2.rsp_zero} !== 35'd0) begin errors++; $display("FAIL reset_rsp_regs: got %h want 0", {a2.rsp_portOut, a2.rsp_negative, a2.rsp_overflow, a2.rsp_zero}); end
    checks++; if ({alu2_a, alu2_b, alu2_op} !== 67'd0) begin errors++; $display("FAIL reset_operands: got %h/%h/%0d want 0/0/0", alu2_a, alu2_b, alu2_op); end
    a2.req_valid = '0;
    RST = 1'b0;
  endtask
  task automatic test_single();
    a2.req_valid = 2'b01; a2.req_aluop[0] = ALU_ADD; a2.req_portA[0] = 32'd5; a2.req_portB[0] = 32'd7;
    #1;
    checks++; if (a2.req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", a2.req_ready); end
    tick();
    a2.req_valid = '0; a2.req_portA[0] = 32'd99;
    #1;
    checks++; if (a2.req_ready !== 2'b00 || a2.rsp_valid !== 2'b00 || a2.busy !== 1'b1) begin errors++; $display("FAIL single_exec: got ready=%b valid=%b busy=%b want 00/00/1", a2.req_ready, a2.rsp_valid, a2.busy); end
    checks++; if (alu2_a !== 32'd5 || alu2_b !== 32'd7 || alu2_op !== ALU_ADD) begin errors++; $display("FAIL single_operands: got %0d/%0d/%0d want 5/7/0", alu2_a, alu2_b, alu2_op); end
    tick();
    checks++; if (a2.rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b want 01", a2.rsp_valid); end
    checks++; if (a2.rsp_portOut !== 32'd12 || {a2.rsp_negative, a2.rsp_overflow, a2.rsp_zero} !== 3'b000) begin errors++; $display("FAIL single_result: got %0d nvz=%b want 12 nvz=000", a2.rsp_portOut, {a2.rsp_negative, a2.rsp_overflow, a2.rsp_zero}); end
    a2.rsp_ready = 2'b01;
    tick();
    a2.rsp_ready = '0;
    #1;
    checks++; if (a2.rsp_valid !== 2'b00 || a2.busy !== 1'b0) begin errors++; $display("FAIL single_done: got valid=%b busy=%b want 00/0", a2.rsp_valid, a2.busy); end
  endtask
  task automatic test_flags();
    a2.req_valid = 2'b10; a2.req_aluop[1] = ALU_SUB; a2.req_portA[1] = 32'd3; a2.req_portB[1] = 32'd3;
    #1;
    checks++; if (a2.req_ready !== 2'b10) begin errors++; $display("FAIL flags_sub_ready: got %b want 10", a2.req_ready); end
    tick();
    a2.req_valid = '0;
    tick();
    checks++; if (a2.rsp_valid !== 2'b10 || a2.rsp_portOut !== 32'd0 || {a2.rsp_negative, a2.rsp_overflow, a2.rsp_zero} !== 3'b001) begin errors++; $display("FAIL flags_sub: got valid=%b out=%h nvz=%b want 10/0/001", a2.rsp_valid, a2.rsp_portOut, {a2.rsp_negative, a2.rsp_overflow, a2.rsp_zero}); end
    a2.rsp_ready = 2'b10;
    tick();
    a2.rsp_ready = '0;
    a2.req_valid = 2'b01; a2.req_aluop[0] = ALU_ADD; a2.req_portA[0] = 32'h7FFFFFFF; a2.req_portB[0] = 32'd1;
    #1;
    checks++; if (a2.req_ready !== 2'b01) begin errors++; $display("FAIL flags_add_ready: got %b want 01", a2.req_ready); end
    tick();
    a2.req_valid = '0;
    tick();
    checks++; if (a2.rsp_valid !== 2'b01 || a2.rsp_portOut !== 32'h80000000 || {a2.rsp_negative, a2.rsp_overflow, a2.rsp_zero} !== 3'b110) begin errors++; $display("FAIL flags_add: got valid=%b out=%h nvz=%b want 01/80000000/110", a2.rsp_valid, a2.rsp_portOut, {a2.rsp_negative, a2.rsp_overflow, a2.rsp_zero}); end
    a2.rsp_ready = 2'b01;
    tick();
    a2.rsp_ready = '0;
  endtask
  task automatic test_contention();
    logic [34:0] e;
    logic [1:0] want;
    do_reset();
    a2.req_valid = 2'b11;
    a2.rsp_ready = 2'b11;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 2; i++) begin a2.req_aluop[i] = aluop_t'($urandom_range(0, 7)); a2.req_portA[i] = $urandom; a2.req_portB[i] = $urandom; end
      want = 2'(1 << (n % 2));
      e = alu_f(a2.req_aluop[n % 2], a2.req_portA[n % 2], a2.req_portB[n % 2]);
      #1;
      checks++; if (a2.req_ready !== want) begin errors++; $display("FAIL contention_grant%0d: got %b want %b", n, a2.req_ready, want); end
      tick();
      for (int i = 0; i < 2; i++) begin a2.req_portA[i] = $urandom; a2.req_portB[i] = $urandom; end
      tick();
      checks++; if (a2.rsp_valid !== want) begin errors++; $display("FAIL contention_route%0d: got %b want %b", n, a2.rsp_valid, want); end
      checks++; if ({a2.rsp_portOut, a2.rsp_negative, a2.rsp_overflow, a2.rsp_zero} !== e) begin errors++; $display("FAIL contention_data%0d: got %h want %h", n, {a2.rsp_portOut, a2.rsp_negative, a2.rsp_overflow, a2.rsp_zero}, e); end
      tick();
    end
    a2.req_valid = '0;
    a2.rsp_ready = '0;
  endtask
  task automatic test_backpressure();
    logic [34:0] e;
    a2.req_valid = 2'b10; a2.req_aluop[1] = ALU_XOR; a2.req_portA[1] = 32'hA5A5_0F0F; a2.req_portB[1] = $urandom;
    e = alu_f(ALU_XOR, 32'hA5A5_0F0F, a2.req_portB[1]);
    #1;
    checks++; if (a2.req_ready !== 2'b10) begin errors++; $display("FAIL bp_ready: got %b want 10", a2.req_ready); end
    tick();
    a2.req_valid = 2'b11;
    tick();
    for (int c = 0; c < 5; c++) begin
      a2.rsp_ready = 2'b01;
      #1;
      checks++; if (a2.rsp_valid !== 2'b10 || a2.req_ready !== 2'b00 || a2.busy !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got valid=%b ready=%b busy=%b want 10/00/1", c, a2.rsp_valid, a2.req_ready, a2.busy); end
      checks++; if ({a2.rsp_portOut, a2.rsp_negative, a2.rsp_overflow, a2.rsp_zero} !== e) begin errors++; $display("FAIL bp_data%0d: got %h want %h", c, {a2.rsp_portOut, a2.rsp_negative, a2.rsp_overflow, a2.rsp_zero}, e); end
      tick();
    end
    a2.rsp_ready = 2'b10;
    #1;
    checks++; if (a2.req_ready !== 2'b00) begin errors++; $display("FAIL bp_no_accept_on_complete: got %b want 00", a2.req_ready); end
    tick();
    a2.req_valid = '0;
    a2.rsp_ready = '0;
    #1;
    checks++; if (d2.state !== IDLE || a2.rsp_valid !== 2'b00 || d2.rr_ptr !== 1'b0) begin errors++; $display("FAIL bp_release: got state=%s valid=%b ptr=%0d want IDLE/00/0", d2.state.name(), a2.rsp_valid, d2.rr_ptr); end
  endtask
  task automatic test_reset_midop();
    a2.req_valid = 2'b01; a2.req_aluop[0] = ALU_ADD; a2.req_portA[0] = 32'd9; a2.req_portB[0] = 32'd4;
    tick();
    a2.req_valid = '0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    checks++; if (d2.state !== IDLE || a2.rsp_valid !== 2'b00 || a2.busy !== 1'b0) begin errors++; $display("FAIL midop_state: got state=%s valid=%b busy=%b want IDLE/00/0", d2.state.name(), a2.rsp_valid, a2.busy); end
    checks++; if (a2.rsp_portOut !== 32'd0 || d2.rr_ptr !== 1'b0) begin errors++; $display("FAIL midop_regs: got out=%h ptr=%0d want 0/0", a2.rsp_portOut, d2.rr_ptr); end
    a2.rsp_ready = 2'b11;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (a2.rsp_valid !== 2'b00 || a2.busy !== 1'b0) begin errors++; $display("FAIL midop_stale%0d: got valid=%b busy=%b want 00/0", c, a2.rsp_valid, a2.busy); end
    end
    a2.rsp_ready = '0;
  endtask
  task automatic test_wrap3();
    do_reset();
    a3.req_valid = 3'b010; a3.req_aluop[1] = ALU_OR; a3.req_portA[1] = 32'h10; a3.req_portB[1] = 32'h01;
    #1;
    checks++; if (a3.req_ready !== 3'b010) begin errors++; $display("FAIL wrap_first: got %b want 010", a3.req_ready); end
    tick();
    a3.req_valid = '0;
    tick();
    a3.rsp_ready = 3'b010;
    tick();
    a3.rsp_ready = '0;
    #1;
    checks++; if (d3.rr_ptr !== 2'd2) begin errors++; $display("FAIL wrap_ptr2: got %0d want 2", d3.rr_ptr); end
    a3.req_valid = 3'b110; a3.req_aluop[2] = ALU_SLL; a3.req_portA[2] = 32'd3; a3.req_portB[2] = 32'd4;
    #1;
    checks++; if (a3.req_ready !== 3'b100) begin errors++; $display("FAIL wrap_grant2: got %b want 100", a3.req_ready); end
    tick();
    checks++; if (d3.rr_ptr !== 2'd0) begin errors++; $display("FAIL wrap_ptr0: got %0d want 0", d3.rr_ptr); end
    tick();
    checks++; if (a3.rsp_valid !== 3'b100 || a3.rsp_portOut !== 32'd48) begin errors++; $display("FAIL wrap_rsp2: got valid=%b out=%0d want 100/48", a3.rsp_valid, a3.rsp_portOut); end
    a3.rsp_ready = 3'b100;
    tick();
    a3.rsp_ready = '0;
    #1;
    checks++; if (a3.req_ready !== 3'b010) begin errors++; $display("FAIL wrap_grant1: got %b want 010", a3.req_ready); end
    tick();
    a3.req_valid = '0;
    tick();
    a3.rsp_ready = 3'b010;
    tick();
    a3.rsp_ready = '0;
  endtask
  task automatic test_random3();
    int ptr, owner, age, w;
    bit inflight, done;
    logic [2:0] er, ev;
    logic [34:0] e;
    do_reset();
    ptr = 0; owner = 0; age = 0; inflight = 0; e = '0;
    for (int c = 0; c < 400; c++) begin
      a3.req_valid = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin a3.req_aluop[i] = aluop_t'($urandom_range(0, 7)); a3.req_portA[i] = $urandom; a3.req_portB[i] = $urandom; end
      a3.rsp_ready = 3'($urandom_range(0, 7));
      #1;
      w = -1; er = '0; ev = '0; done = 0;
      if (!inflight) begin
        for (int k = 0; k < 3; k++) if (w < 0 && a3.req_valid[2'((ptr + k) % 3)]) w = (ptr + k) % 3;
        if (w >= 0) er = 3'(1 << w);
      end else if (age >= 2) begin
        ev = 3'(1 << owner);
        done = a3.rsp_ready[2'(owner)];
      end
      checks++; if (a3.req_ready !== er || a3.rsp_valid !== ev || a3.busy !== inflight) begin errors++; $display("FAIL rand_ctl c=%0d: got ready=%b valid=%b busy=%b want %b/%b/%b", c, a3.req_ready, a3.rsp_valid, a3.busy, er, ev, inflight); end
      if (inflight && age >= 2) begin
        checks++; if ({a3.rsp_portOut, a3.rsp_negative, a3.rsp_overflow, a3.rsp_zero} !== e) begin errors++; $display("FAIL rand_data c=%0d: got %h want %h", c, {a3.rsp_portOut, a3.rsp_negative, a3.rsp_overflow, a3.rsp_zero}, e); end
      end
      if (inflight) begin
        if (done) inflight = 0;
        else age++;
      end else if (w >= 0) begin
        inflight = 1; age = 1; owner = w; ptr = (w + 1) % 3;
        e = alu_f(a3.req_aluop[2'(w)], a3.req_portA[2'(w)], a3.req_portB[2'(w)]);
      end
      tick();
    end
    a3.req_valid = '0;
    a3.rsp_ready = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single();
    test_flags();
    test_contention();
    test_backpressure();
    test_reset_midop();
    test_wrap3();
    test_random3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between NREQ requesters; in the dual-core build these are core0 and core1 execute-side helper units.
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- The block picks one request round-robin, registers its operands into the ALU, captures the result and flags, and holds them until the owner accepts.
- One operation is in flight at a time. The block sits between the requesters and the ALU's rf modport.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- PTR_W, $clog2(NREQ), width of the round-robin pointer and owner index (derived; not overridden).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- req_valid  input  [NREQ]  requester i presents an operation.
- req_ready  output  [NREQ]  request i accepted this cycle (one-hot or zero).
- req_aluop  input  [NREQ] x aluop_t  operation per requester.
- req_portA  input  [NREQ] x word_t  operand A per requester.
- req_portB  input  [NREQ] x word_t  operand B per requester.
- rsp_valid  output  [NREQ]  result ready for requester i (one-hot or zero).
- rsp_ready  input  [NREQ]  requester i accepts the result.
- rsp_portOut  output  word_t  registered result, shared by all requesters; qualified by rsp_valid.
- rsp_negative, rsp_overflow, rsp_zero  output  1 each  registered flags.
- busy  output  1  high whenever state != IDLE.
- alu_portA, alu_portB  output  word_t  to ALU rf modport inputs.
- alu_aluop  output  aluop_t  to ALU.
- alu_portOut  input  word_t  from ALU.
- alu_negative, alu_overflow, alu_zero  input  1 each  from ALU.

Behaviour:
- One clock (CLK). Reset RST is synchronous and active-high.
- Reset values:
  - state = IDLE, rr_ptr = 0, owner = 0.
  - Operand registers (A, B, aluop) = 0; aluop is aluop_t'(0).
  - rsp_portOut and all rsp flags = 0.
  - rsp_valid = 0, req_ready = 0, busy = 0.
- alu_* outputs are driven only from the operand registers, never combinationally from req_* inputs.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - If any request is valid: req_ready[winner] = 1 combinationally this cycle; latch winner's aluop/A/B; owner <= winner; rr_ptr <= (winner+1) mod NREQ; go to EXEC.
  - If no request is valid: stay in IDLE; rr_ptr is unchanged.
- EXEC (exactly 1 cycle):
  - The ALU evaluates the registered operands.
  - Capture alu_portOut and the three flags into the rsp registers; go to RESP.
- RESP:
  - rsp_valid[owner] = 1; all other rsp_valid bits = 0.
  - Outputs hold stable until rsp_ready[owner] = 1; on that edge go to IDLE.
  - rsp_ready from non-owners is ignored.
- req_ready is 0 in EXEC and RESP. A new request is never accepted on the same cycle a response completes.
- Timing:
  - Minimum turnaround is 3 cycles per operation.
  - Request accepted at cycle t, rsp_valid first high at t+2.
- A requester may drop req_valid before it is granted; this has no effect. Operands are sampled only on the accept cycle.
- Simultaneous requests: exactly one is granted; the loser keeps waiting.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0,...
- Reset mid-operation (EXEC or RESP): the in-flight result is dropped and no rsp_valid is issued; outputs take reset values next cycle.
- Width rules: no arithmetic other than the pointer increment, which wraps modulo NREQ (including non-power-of-2 NREQ=3).

Decomposition:
- aluop_t and word_t come from cpu_types_pkg.
- Add arbstate_t (IDLE, EXEC, RESP) to cpu_types_pkg so the bench can probe state.
- Sub-module rr_picker (combinational): inputs valid vector and rr_ptr; outputs one-hot grant and winner index. It is reusable for the later memory arbiter.
- A companion interface alu_arb_if with modports arb and tb groups the requester-side signals.

Test Plan:
- Single request: after reset, req_valid[0] with ALU_ADD, A=5, B=7. Required: req_ready[0] at t; rsp_valid[0] at t+2; rsp_portOut=12, zero=0, negative=0, overflow=0.
- Flags: ALU_SUB, A=3, B=3, then ALU_ADD, A=0x7FFFFFFF, B=1. Required: first gives portOut=0, zero=1; second gives portOut=0x80000000, overflow=1, negative=1.
- Contention: both requesters valid every cycle for 4 ops (rr_ptr=0 after reset). Required: grant order 0,1,0,1, and each response routed only to its own rsp_valid bit.
- Backpressure: hold rsp_ready[1]=0 for 5 cycles while in RESP. Required: rsp_valid[1] and rsp_portOut stay stable, req_ready stays 0, busy=1; rsp_ready[0]=1 in that window has no effect.
- Reset mid-op: assert RST during EXEC. Required: next cycle state=IDLE, rsp_valid=0, rsp_portOut=0, rr_ptr=0; no stale response afterwards.
- NREQ=3 wrap: requesters 1 and 2 valid, rr_ptr=2. Required: grant 2, then rr_ptr wraps to 0, next grant 1.
